// File: rtl/ucc_sequencer.sv
// Command sequencer for an up/down counter chain: loads a start value, counts
// toward a terminal value with pause/stop/auto-reload, and flags done and wrap.
module ucc_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_dir,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic [WIDTH-1:0] i_term_val,
    input  logic             i_reload,
    input  logic             i_pause,
    input  logic             i_stop,
    output logic [1:0]       o_mode_c,
    output logic [WIDTH-1:0] o_pin,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_wrap
);

    localparam int unsigned MODE_W = 2;
    localparam logic [MODE_W-1:0] MODE_HOLD = 2'b00;
    localparam logic [MODE_W-1:0] MODE_UP   = 2'b01;
    localparam logic [MODE_W-1:0] MODE_LOAD = 2'b11;
    localparam logic [MODE_W-1:0] MODE_DOWN = 2'b10;
    localparam logic [WIDTH-1:0]  ALL_ONES  = '1;
    localparam logic [WIDTH-1:0]  ZERO      = '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_dir;
    logic [WIDTH-1:0]  r_load;
    logic [WIDTH-1:0]  r_term;
    logic              r_reload;
    logic [WIDTH-1:0]  r_count;
    logic              r_busy;
    logic              r_done;
    logic              r_wrap;

    logic [MODE_W-1:0] w_mode;
    logic              w_capture;
    logic              w_load_cnt;
    logic              w_step;
    logic              w_reload_clr;
    logic              w_wrap;
    logic [WIDTH-1:0]  w_count_step;

    assign w_count_step = r_dir ? (r_count - WIDTH'(1)) : (r_count + WIDTH'(1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control decode; stop outranks pause, pause outranks counting
    always_comb begin
        w_state_nxt  = r_state;
        w_mode       = MODE_HOLD;
        w_capture    = 1'b0;
        w_load_cnt   = 1'b0;
        w_step       = 1'b0;
        w_reload_clr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (i_stop) begin
                    w_reload_clr = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_mode      = MODE_LOAD;
                    w_load_cnt  = 1'b1;
                    w_state_nxt = (r_load == r_term) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (i_stop) begin
                    w_reload_clr = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else if (!i_pause) begin
                    w_mode = r_dir ? MODE_DOWN : MODE_UP;
                    w_step = 1'b1;
                    if (w_count_step == r_term) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (i_stop) begin
                    w_reload_clr = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_state_nxt = r_reload ? S_LOAD : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_wrap = w_step && (r_dir ? (r_count == ZERO) : (r_count == ALL_ONES));

    // Captured command, count and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dir    <= 1'b0;
            r_load   <= '0;
            r_term   <= '0;
            r_reload <= 1'b0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_dir    <= i_dir;
                r_load   <= i_load_val;
                r_term   <= i_term_val;
                r_reload <= i_reload;
            end else if (w_reload_clr) begin
                r_reload <= 1'b0;
            end
            if (w_load_cnt) begin
                r_count <= r_load;
            end else if (w_step) begin
                r_count <= w_count_step;
            end
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_DONE);
            r_wrap <= w_wrap;
        end
    end

    assign o_mode_c = w_mode;
    assign o_pin    = r_load;
    assign o_count  = r_count;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_wrap   = r_wrap;

endmodule

// File: tb/tb_ucc_sequencer.sv
// Randomized scoreboard bench for ucc_sequencer: expected done events are
// predicted from command arithmetic and checked by an independent monitor.
module tb_ucc_sequencer;

    localparam int unsigned W    = 8;
    localparam int unsigned MASK = (1 << W) - 1;

    logic         clk;
    logic         rst;
    logic         i_start;
    logic         i_dir;
    logic [W-1:0] i_load_val;
    logic [W-1:0] i_term_val;
    logic         i_reload;
    logic         i_pause;
    logic         i_stop;
    logic [1:0]   o_mode_c;
    logic [W-1:0] o_pin;
    logic [W-1:0] o_count;
    logic         o_busy;
    logic         o_done;
    logic         o_wrap;

    ucc_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_dir      (i_dir),
        .i_load_val (i_load_val),
        .i_term_val (i_term_val),
        .i_reload   (i_reload),
        .i_pause    (i_pause),
        .i_stop     (i_stop),
        .o_mode_c   (o_mode_c),
        .o_pin      (o_pin),
        .o_count    (o_count),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_wrap     (o_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cnt;
        int unsigned cyc;
        int unsigned wraps;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned wrap_seen = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: edges spent counting, and whether the path crosses the modulo boundary
    function automatic int unsigned steps_of(input bit dir, input int unsigned l, input int unsigned t);
        return dir ? ((l - t) & MASK) : ((t - l) & MASK);
    endfunction

    function automatic int unsigned wraps_of(input bit dir, input int unsigned l, input int unsigned s);
        if (dir) return (s > l) ? 1 : 0;
        return (l + s > MASK) ? 1 : 0;
    endfunction

    // Monitor: every done pulse must match the oldest prediction
    always @(negedge clk) begin
        if (!rst) begin
            if (o_wrap) wrap_seen++;
            if (o_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_count", o_count, e.cnt);
                    check("done_cycle", cyc, e.cyc);
                    check("done_wraps", wrap_seen, e.wraps);
                end
                wrap_seen = 0;
            end
            if (!o_busy) wrap_seen = 0;
        end
    end

    task automatic junk_cmd_inputs();
        i_dir      = 1'($urandom_range(0, 1));
        i_load_val = W'($urandom);
        i_term_val = W'($urandom);
        i_reload   = 1'($urandom_range(0, 1));
    endtask

    task automatic start_cmd(input bit dir, input int unsigned l, input int unsigned t,
                             input bit rl, output int unsigned e0);
        i_dir      = dir;
        i_load_val = W'(l);
        i_term_val = W'(t);
        i_reload   = rl;
        i_start    = 1'b1;
        e0         = cyc + 1;
        @(negedge clk);
        i_start = 1'b0;
        junk_cmd_inputs();
    endtask

    task automatic wait_idle();
        int unsigned k;
        k = 0;
        while (o_busy && k < 3000) begin
            i_start = ($urandom_range(0, 5) == 0);
            junk_cmd_inputs();
            @(negedge clk);
            i_start = 1'b0;
            k++;
        end
        check("idle_reached", o_busy, 0);
    endtask

    task automatic run_cmd(input bit dir, input int unsigned l, input int unsigned t,
                           input int unsigned plen, input bit trace);
        int unsigned s, e0, pl, j, held, prev;
        s  = steps_of(dir, l, t);
        pl = (s > 0 && !trace) ? plen : 0;
        start_cmd(dir, l, t, 1'b0, e0);
        sb.push_back('{t, e0 + 1 + s + pl, wraps_of(dir, l, s)});
        check("load_mode", o_mode_c, 3);
        check("load_pin", o_pin, l);
        check("load_busy", o_busy, 1);
        if (trace) begin
            for (int i = 0; i <= int'(s); i++) begin
                @(negedge clk);
                check("trace_count", o_count, (dir ? (l - i) : (l + i)) & MASK);
                prev = (dir ? (l - i + 1) : (l + i - 1)) & MASK;
                check("trace_wrap", o_wrap, (i > 0 && (dir ? prev == 0 : prev == MASK)) ? 1 : 0);
                if (i < int'(s)) check("trace_mode", o_mode_c, dir ? 2 : 1);
            end
            @(negedge clk);
            check("busy_fall", o_busy, 0);
        end else if (pl > 0) begin
            j = $urandom_range(0, s - 1);
            repeat (j + 1) @(negedge clk);
            held    = o_count;
            i_pause = 1'b1;
            #1;
            check("pause_mode", o_mode_c, 0);
            for (int p = 0; p < int'(pl); p++) begin
                @(negedge clk);
                check("pause_hold", o_count, held);
            end
            i_pause = 1'b0;
        end
        wait_idle();
        check("final_count", o_count, t);
    endtask

    task automatic stop_cmd(input bit dir, input int unsigned l, input int unsigned s);
        int unsigned e0, j, t;
        t = (dir ? (l - s) : (l + s)) & MASK;
        j = $urandom_range(0, s - 1);
        start_cmd(dir, l, t, 1'b0, e0);
        repeat (j + 1) @(negedge clk);
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        check("stop_busy", o_busy, 0);
        check("stop_count", o_count, (dir ? (l - j) : (l + j)) & MASK);
        check("stop_done", o_done, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned e0, n, k;
        rst = 1'b1;
        i_start = 1'b0; i_dir = 1'b0; i_load_val = '0; i_term_val = '0;
        i_reload = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
        @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_count", o_count, 0);
        check("rst_mode", o_mode_c, 0);
        check("rst_done", o_done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_cmd(1'b0, 3, 6, 0, 1'b1);
        run_cmd(1'b1, 2, 254, 0, 1'b1);
        run_cmd(1'b0, 9, 9, 0, 1'b1);
        run_cmd(1'b0, 255, 0, 0, 1'b1);
        run_cmd(1'b1, 0, 255, 0, 1'b1);
        run_cmd(1'b0, 10, 20, 3, 1'b0);

        // Auto-reload: two periods, then stop in RUN
        start_cmd(1'b0, 0, 2, 1'b1, e0);
        sb.push_back('{2, e0 + 3, 0});
        sb.push_back('{2, e0 + 7, 0});
        n = 0; k = 0;
        while (n < 2 && k < 100) begin
            @(negedge clk);
            k++;
            if (o_done) n++;
        end
        check("reload_dones", n, 2);
        repeat (2) @(negedge clk);
        check("reload_run_count", o_count, 0);
        check("reload_run_mode", o_mode_c, 1);
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        check("reload_stop_busy", o_busy, 0);
        repeat (10) @(negedge clk);
        check("reload_stays_idle", o_busy, 0);
        check("reload_count_held", o_count, 0);

        // Asynchronous reset between edges mid-RUN
        start_cmd(1'b0, 0, 200, 1'b0, e0);
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", o_busy, 0);
        check("arst_count", o_count, 0);
        check("arst_mode", o_mode_c, 0);
        check("arst_done", o_done, 0);
        check("arst_wrap", o_wrap, 0);
        check("arst_pin", o_pin, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_busy", o_busy, 0);
        check("post_rst_count", o_count, 0);

        for (int c = 0; c < 30; c++) begin
            run_cmd(1'($urandom_range(0, 1)), $urandom_range(0, MASK), $urandom_range(0, MASK),
                    $urandom_range(0, 1) ? $urandom_range(1, 4) : 0, 1'b0);
        end
        for (int c = 0; c < 8; c++) begin
            stop_cmd(1'($urandom_range(0, 1)), $urandom_range(0, MASK), $urandom_range(2, 40));
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
